// File: rtl/pkg_serial.sv
// Shared types and helpers for the serial receive deframer.
// Optional parity support in the deframer is enabled by defining SERIAL_RX_PARITY_EN.
package pkg_serial;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } rx_state_t;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned MID_SAMPLE = 7;

    // Clocks per oversample tick, truncated; never less than one clock.
    function automatic int unsigned calc_div(input int unsigned clk_freq, input int unsigned baud);
        int unsigned div;
        div = clk_freq / (baud * OVERSAMPLE);
        return (div == 0) ? 1 : div;
    endfunction

endpackage

// File: rtl/serial_rx_fifo.sv
// Small output FIFO for received words; head word is shown combinationally.
// Part of serial_rx_deframer (parity option: SERIAL_RX_PARITY_EN, unused here).
module serial_rx_fifo #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_din,
    output logic              o_full,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_dout,
    output logic              o_empty
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    logic [AW:0]       r_wp;
    logic [AW:0]       r_rp;
    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];

    logic w_full;
    logic w_empty;
    logic w_do_pop;
    logic w_do_push;

    // Extra pointer MSB distinguishes full from empty.
    assign w_full    = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
    assign w_empty   = (r_wp == r_rp);
    assign w_do_pop  = i_pop && !w_empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is accepted then.
    assign w_do_push = i_push && (!w_full || w_do_pop);

    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_dout  = r_mem[r_rp[AW-1:0]];

    // Storage and pointer update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp <= '0;
            r_rp <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wp[AW-1:0]] <= i_din;
                r_wp                <= r_wp + 1'b1;
            end
            if (w_do_pop) begin
                r_rp <= r_rp + 1'b1;
            end
        end
    end

endmodule

// File: rtl/serial_rx_deframer.sv
// 16x oversampling serial receiver: recovers start/data/stop frames from rx_i,
// buffers completed words in serial_rx_fifo and presents them on valid/ready.
// Define SERIAL_RX_PARITY_EN to insert an even-parity bit after the data bits.
module serial_rx_deframer
    import pkg_serial::*;
#(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              frame_err_o,
    output logic              parity_err_o,
    output logic              overrun_o
);

    localparam int unsigned DIV = calc_div(CLK_FREQ, BAUD);
    localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned IW  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [3:0]    SCNT_MID  = 4'(MID_SAMPLE);
    localparam logic [3:0]    SCNT_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_W - 1);

    logic              r_sync1;
    logic              r_sync2;
    logic [CW-1:0]     r_div_cnt;
    rx_state_t         r_state;
    logic [3:0]        r_scnt;
    logic [IW-1:0]     r_idx;
    logic [DATA_W-1:0] r_shift;
    logic              r_frame_err;
    logic              r_overrun;
`ifdef SERIAL_RX_PARITY_EN
    logic              r_par_err;
    logic              r_par_bad;
`endif

    logic              w_rxs;
    logic              w_tick;
    logic              w_start;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic              w_word_ok;
    logic [DATA_W-1:0] w_dout;

    assign w_rxs   = r_sync2;
    assign w_tick  = (r_div_cnt == DIV_LAST);
    assign w_start = (r_state == IDLE) && !w_rxs;

`ifdef SERIAL_RX_PARITY_EN
    assign w_word_ok    = !r_par_bad;
    assign parity_err_o = r_par_err;
`else
    assign w_word_ok    = 1'b1;
    assign parity_err_o = 1'b0;
`endif

    // Word is complete when the stop bit samples high; push happens in that same cycle.
    assign w_push = (r_state == STOP) && w_tick && (r_scnt == SCNT_LAST) && w_rxs && w_word_ok;
    assign w_pop  = ready_i && !w_empty;

    assign data_o      = w_dout;
    assign valid_o     = !w_empty;
    assign frame_err_o = r_frame_err;
    assign overrun_o   = r_overrun;

    // Two-flop synchroniser; idles high so reset does not look like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx_i;
            r_sync2 <= r_sync1;
        end
    end

    // Oversample tick divider, realigned to the detected start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div_cnt <= '0;
        end else if (w_start || w_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + CW'(1);
        end
    end

    // Frame FSM with registered error pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_scnt      <= '0;
            r_idx       <= '0;
            r_shift     <= '0;
            r_frame_err <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            r_par_err   <= 1'b0;
            r_par_bad   <= 1'b0;
`endif
        end else begin
            r_frame_err <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            r_par_err   <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (!w_rxs) begin
                        r_state <= START;
                        r_scnt  <= '0;
                    end
                end
                START: begin
                    if (w_tick) begin
                        if (r_scnt == SCNT_MID) begin
                            if (!w_rxs) begin
                                r_state <= DATA;
                                r_scnt  <= '0;
                                r_idx   <= '0;
`ifdef SERIAL_RX_PARITY_EN
                                r_par_bad <= 1'b0;
`endif
                            end else begin
                                // Line went back high before mid-bit: glitch.
                                r_state <= IDLE;
                            end
                        end else begin
                            r_scnt <= r_scnt + 4'd1;
                        end
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        r_scnt <= r_scnt + 4'd1;
                        if (r_scnt == SCNT_LAST) begin
                            r_shift[r_idx] <= w_rxs;
                            if (r_idx == IDX_LAST) begin
`ifdef SERIAL_RX_PARITY_EN
                                r_state <= PARITY;
`else
                                r_state <= STOP;
`endif
                            end else begin
                                r_idx <= r_idx + IW'(1);
                            end
                        end
                    end
                end
`ifdef SERIAL_RX_PARITY_EN
                PARITY: begin
                    if (w_tick) begin
                        r_scnt <= r_scnt + 4'd1;
                        if (r_scnt == SCNT_LAST) begin
                            if ((^r_shift) ^ w_rxs) begin
                                r_par_err <= 1'b1;
                                r_par_bad <= 1'b1;
                            end
                            r_state <= STOP;
                        end
                    end
                end
`endif
                STOP: begin
                    if (w_tick) begin
                        r_scnt <= r_scnt + 4'd1;
                        if (r_scnt == SCNT_LAST) begin
                            if (w_rxs) begin
                                r_state <= IDLE;
                            end else begin
                                r_frame_err <= 1'b1;
                                r_state     <= WAIT_HIGH;
                            end
                        end
                    end
                end
                WAIT_HIGH: begin
                    // Hold off while the line is in a break so it cannot re-trigger.
                    if (w_rxs) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Overrun: completed word arrives while the FIFO is full and nothing leaves.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= w_push && w_full && !w_pop;
        end
    end

    serial_rx_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_din   (r_shift),
        .o_full  (w_full),
        .i_pop   (w_pop),
        .o_dout  (w_dout),
        .o_empty (w_empty)
    );

endmodule

// File: tb/tb_serial_rx_deframer.sv
// Directed and randomized checks of serial_rx_deframer at DIV=10 (160 clocks per bit).
module tb_serial_rx_deframer;

    localparam int unsigned CLK_FREQ   = 1_600_000;
    localparam int unsigned BAUD       = 10_000;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned FIFO_DEPTH = 4;

    localparam int DIV = CLK_FREQ / (BAUD * 16);
    localparam int BIT = DIV * 16;
`ifdef SERIAL_RX_PARITY_EN
    localparam int PBITS = 1;
`else
    localparam int PBITS = 0;
`endif
    localparam int NBITS = 10 + PBITS;
    // Start edge to valid_o: 2 sync flops + 1 detect clock, half a start bit (8 ticks),
    // then 16 ticks for every data/parity/stop bit.
    localparam int LAT = 3 + DIV * 8 + BIT * (DATA_W + 1 + PBITS);

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_i;
    logic [7:0]  data_o;
    logic        valid_o;
    logic        ready_i;
    logic        frame_err_o;
    logic        parity_err_o;
    logic        overrun_o;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_ferr = 0;
    int          n_perr = 0;
    int          n_ovr = 0;
    int          exp_perr = 0;
    logic [7:0]  got_q[$];
    logic [7:0]  exp_q[$];
    int          rd_idx = 0;

    serial_rx_deframer #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_i         (rx_i),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .frame_err_o  (frame_err_o),
        .parity_err_o (parity_err_o),
        .overrun_o    (overrun_o)
    );

    always #5 clk = ~clk;

    // Record every accepted word and every error pulse, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (valid_o && ready_i) got_q.push_back(data_o);
            if (frame_err_o) n_ferr++;
            if (parity_err_o) n_perr++;
            if (overrun_o) n_ovr++;
        end
    end

    initial begin
        #(90_000 * 10);
        $display("FAIL watchdog: observed timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one frame LSB first; the line is left at the stop-bit level.
    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_flip);
        logic [10:0] f;
        logic        par;
        par = (^d) ^ par_flip;
`ifdef SERIAL_RX_PARITY_EN
        f = {stop_b, par, d, 1'b0};
`else
        f = {par, stop_b, d, 1'b0};
`endif
        @(posedge clk);
        #1;
        for (int i = 0; i < NBITS; i++) begin
            rx_i = f[i];
            repeat (BIT) @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(input string tag);
        int t;
        t = 0;
        ready_i = 1'b1;
        while (valid_o && t < 64) begin
            @(posedge clk);
            #1;
            t++;
        end
        check({tag, "_drained"}, valid_o, 1'b0);
        wait_clks(2);
        ready_i = 1'b0;
    endtask

    task automatic check_words(input string tag);
        int n;
        n = got_q.size() - rd_idx;
        check({tag, "_count"}, n, exp_q.size());
        for (int i = 0; i < exp_q.size() && i < n; i++) begin
            check({tag, "_word"}, got_q[rd_idx + i], exp_q[i]);
        end
        rd_idx = got_q.size();
        exp_q.delete();
    endtask

    initial begin
        int bf;
        int bo;
        int b;
        logic [7:0] d;

        rst = 1'b1;
        rx_i = 1'b1;
        ready_i = 1'b0;
        wait_clks(5);
        check("rst_valid", valid_o, 1'b0);
        check("rst_data", data_o, 8'h00);
        check("rst_ferr", frame_err_o, 1'b0);
        check("rst_perr", parity_err_o, 1'b0);
        check("rst_ovr", overrun_o, 1'b0);
        rst = 1'b0;
        wait_clks(5);

        // Single frame and its exact output latency.
        bf = n_ferr;
        bo = n_ovr;
        fork
            send_frame(8'hA5, 1'b1, 1'b0);
            begin
                @(posedge clk);
                repeat (LAT - 1) @(posedge clk);
                #1;
                check("lat_before", valid_o, 1'b0);
                @(posedge clk);
                #1;
                check("lat_valid", valid_o, 1'b1);
                check("lat_data", data_o, 8'hA5);
            end
        join
        check("a5_ferr", n_ferr - bf, 0);
        check("a5_ovr", n_ovr - bo, 0);
        exp_q.push_back(8'hA5);
        drain("a5");
        check_words("a5");

        // Back-to-back frames into a stalled consumer overflow the FIFO.
        bo = n_ovr;
        for (int i = 1; i <= 6; i++) send_frame(8'(i), 1'b1, 1'b0);
        check("full_valid", valid_o, 1'b1);
        check("full_head", data_o, 8'h01);
        wait_clks(20);
        check("full_head_stable", data_o, 8'h01);
        check("full_ovr", n_ovr - bo, 2);
        for (int i = 1; i <= 4; i++) exp_q.push_back(8'(i));
        drain("full");
        check_words("full");

        // Stop bit low followed by a break: one frame error, no word, no re-trigger.
        bf = n_ferr;
        send_frame(8'h3C, 1'b0, 1'b0);
        rx_i = 1'b0;
        wait_clks(3 * BIT);
        rx_i = 1'b1;
        wait_clks(2 * BIT);
        check("brk_ferr", n_ferr - bf, 1);
        check("brk_valid", valid_o, 1'b0);
        send_frame(8'h5A, 1'b1, 1'b0);
        check("brk_ferr_after", n_ferr - bf, 1);
        exp_q.push_back(8'h5A);
        drain("brk");
        check_words("brk");

        // Short low glitch on an idle line is ignored.
        bf = n_ferr;
        rx_i = 1'b0;
        wait_clks(3);
        rx_i = 1'b1;
        wait_clks(2 * BIT);
        check("gl_valid", valid_o, 1'b0);
        check("gl_ferr", n_ferr - bf, 0);
        send_frame(8'hC3, 1'b1, 1'b0);
        exp_q.push_back(8'hC3);
        drain("gl");
        check_words("gl");

        // Reset mid-frame flushes the FIFO and the partial word.
        send_frame(8'h77, 1'b1, 1'b0);
        check("pre_rst_valid", valid_o, 1'b1);
        check("pre_rst_data", data_o, 8'h77);
        rx_i = 1'b0;
        wait_clks(BIT);
        rx_i = 1'b1;
        wait_clks(BIT);
        rx_i = 1'b0;
        wait_clks(BIT / 2);
        rst = 1'b1;
        rx_i = 1'b1;
        wait_clks(1);
        check("in_rst_valid", valid_o, 1'b0);
        check("in_rst_data", data_o, 8'h00);
        wait_clks(4);
        rst = 1'b0;
        wait_clks(2 * BIT);
        check("post_rst_valid", valid_o, 1'b0);
        send_frame(8'h33, 1'b1, 1'b0);
        exp_q.push_back(8'h33);
        drain("rst");
        check_words("rst");

`ifdef SERIAL_RX_PARITY_EN
        // Wrong parity drops the word; correct parity delivers it.
        send_frame(8'h07, 1'b1, 1'b1);
        exp_perr++;
        check("par_bad_perr", n_perr, exp_perr);
        check("par_bad_valid", valid_o, 1'b0);
        send_frame(8'h07, 1'b1, 1'b0);
        check("par_ok_perr", n_perr, exp_perr);
        exp_q.push_back(8'h07);
        drain("par");
        check_words("par");
`endif

        // Random bursts into a stalled consumer: first FIFO_DEPTH words kept, rest overrun.
        for (int r = 0; r < 3; r++) begin
            b = $urandom_range(1, FIFO_DEPTH + 2);
            bo = n_ovr;
            for (int j = 0; j < b; j++) begin
                d = 8'($urandom);
                wait_clks($urandom_range(0, BIT));
                send_frame(d, 1'b1, 1'b0);
                if (j < FIFO_DEPTH) exp_q.push_back(d);
            end
            check("rnd_ovr", n_ovr - bo, (b > FIFO_DEPTH) ? b - FIFO_DEPTH : 0);
            drain("rnd");
            check_words("rnd");
        end

        check("total_ferr", n_ferr, 1);
        check("total_perr", n_perr, exp_perr);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
